// File: rtl/key_event_gen_if.sv
// Key event bundle: debounced key level in, one-cycle key events plus held level out.
interface key_event_gen_if;
  logic key_n;
  logic press;
  logic release_pulse;
  logic long_press;
  logic repeat_tick;
  logic held;

  modport master (output key_n, input press, release_pulse, long_press, repeat_tick, held);
  modport slave  (input key_n, output press, release_pulse, long_press, repeat_tick, held);
endinterface

// File: rtl/key_event_gen.sv
// Turns a debounced active-low key level into press/release/long-press/repeat pulses
// and a held level; one shared counter times both the long-press and repeat periods.
module key_event_gen #(
    parameter int HOLD_TICKS   = 25000000,
    parameter int REPEAT_TICKS = 5000000,
    parameter int CNT_W        = 25
) (
    input logic             clk,
    input logic             rst,
    key_event_gen_if.slave  kif
);
    typedef enum logic [1:0] {IDLE, DOWN, HOLD} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            cnt               <= '0;
            kif.press         <= 1'b0;
            kif.release_pulse <= 1'b0;
            kif.long_press    <= 1'b0;
            kif.repeat_tick   <= 1'b0;
            kif.held          <= 1'b0;
        end else begin
            kif.press         <= 1'b0;
            kif.release_pulse <= 1'b0;
            kif.long_press    <= 1'b0;
            kif.repeat_tick   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!kif.key_n) begin
                        state     <= DOWN;
                        cnt       <= '0;
                        kif.press <= 1'b1;
                        kif.held  <= 1'b1;
                    end
                end
                DOWN: begin
                    // key-up takes priority over a terminal count on the same edge
                    if (kif.key_n) begin
                        state             <= IDLE;
                        cnt               <= '0;
                        kif.release_pulse <= 1'b1;
                        kif.held          <= 1'b0;
                    end else if (cnt == HOLD_LAST) begin
                        state          <= HOLD;
                        cnt            <= '0;
                        kif.long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (kif.key_n) begin
                        state             <= IDLE;
                        cnt               <= '0;
                        kif.release_pulse <= 1'b1;
                        kif.held          <= 1'b0;
                    end else if (cnt == REPEAT_LAST) begin
                        cnt             <= '0;
                        kif.repeat_tick <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    kif.held <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_event_gen.sv
// Directed + random bench for key_event_gen; expectations come from a run-length
// model of how many consecutive edges have sampled the key down.
module tb_key_event_gen;
    localparam int HT = 8;
    localparam int RT = 3;
    localparam int CW = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   run;       // consecutive edges sampled with key down (0 = idle)
    int   rep_seen;

    key_event_gen_if kif ();

    key_event_gen #(.HOLD_TICKS(HT), .REPEAT_TICKS(RT), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ep, input logic er,
                           input logic el, input logic erp, input logic eh);
        logic onehot;
        chk({tag, ".press"},       kif.press,         ep);
        chk({tag, ".release"},     kif.release_pulse, er);
        chk({tag, ".long_press"},  kif.long_press,    el);
        chk({tag, ".repeat_tick"}, kif.repeat_tick,   erp);
        chk({tag, ".held"},        kif.held,          eh);
        onehot = ($countones({kif.press, kif.release_pulse, kif.long_press, kif.repeat_tick}) <= 1);
        chk({tag, ".onehot"}, onehot, 1'b1);
        if (kif.repeat_tick === 1'b1) rep_seen++;
    endtask

    // Drive key level (called just after an edge), clock once, predict, check.
    task automatic step(input string tag, input logic kn);
        logic ep, er, el, erp;
        kif.key_n = kn;
        @(posedge clk);
        ep = 1'b0; er = 1'b0; el = 1'b0; erp = 1'b0;
        if (!rst) begin
            run = 0;
        end else if (!kn) begin
            if (run == 0) ep = 1'b1;
            else if (run == HT) el = 1'b1;
            else if (run > HT && ((run - HT) % RT) == 0) erp = 1'b1;
            run++;
        end else begin
            if (run > 0) er = 1'b1;
            run = 0;
        end
        #1;
        chk_all(tag, ep, er, el, erp, run > 0);
    endtask

    task automatic steps(input string tag, input logic kn, input int n);
        for (int i = 0; i < n; i++) step(tag, kn);
    endtask

    initial begin
        logic lvl;
        int   n;
        total = 0; bad = 0; run = 0; rep_seen = 0;
        rst = 1'b0;
        kif.key_n = 1'b1;
        #1;
        chk_all("reset_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset held while key toggles
        for (int i = 0; i < 6; i++) step("reset_toggle", logic'(i[0]));
        #2 rst = 1'b1;
        steps("post_reset_idle", 1'b1, 3);

        // Short press
        steps("short_down", 1'b0, 5);
        steps("short_up", 1'b1, 3);

        // Release exactly at the long-press terminal count
        steps("tc_down", 1'b0, 8);
        steps("tc_up", 1'b1, 2);

        // Long hold with three repeats, fourth suppressed by release
        rep_seen = 0;
        steps("long_down", 1'b0, 20);
        steps("long_up", 1'b1, 2);
        total++;
        assert (rep_seen == 3) else begin
            bad++;
            $error("FAIL long_repeat_count observed=%0d expected=%0d", rep_seen, 3);
        end

        // Async reset while in HOLD, then restart with key still down
        steps("rmid_down", 1'b0, 12);
        #2 rst = 1'b0;
        #1;
        run = 0;
        chk_all("rmid_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        steps("rmid_inreset", 1'b0, 2);
        #2 rst = 1'b1;
        steps("rmid_restart", 1'b0, 10);
        steps("rmid_up", 1'b1, 2);

        // Back-to-back release/press
        steps("b2b_down", 1'b0, 2);
        step("b2b_up", 1'b1);
        step("b2b_repress", 1'b0);
        steps("b2b_end", 1'b1, 2);

        // Random run lengths
        lvl = 1'b0;
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(1, 25);
            steps("random", lvl, n);
            lvl = ~lvl;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
